// File: rtl/uart_sender.sv
// uart_sender: byte FIFO feeding an 8N1 serial transmitter.
// Bytes written through tx_en/tx_data are queued, then shifted out LSB first
// with one start and one stop bit, each bit lasting CLKS_PER_BIT clocks.
// Consecutive queued bytes are sent back to back with no idle gap.
module uart_sender #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               tx_data,
    input  logic                     tx_en,
    output logic                     tx_ready,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     uart_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic [BW-1:0] r_baud;
    logic          r_tx;

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_empty;
    logic          w_baud_end;
    logic          w_tx_next;
    logic [2:0]    w_bit_idx_inc;

    assign w_fifo_empty  = (r_count == '0);
    assign w_baud_end    = (r_baud == BAUD_LAST);
    assign w_bit_idx_inc = r_bit_idx + 3'd1;
    assign w_push        = tx_en && tx_ready;

    assign tx_ready   = (r_count < FULL_COUNT);
    assign tx_busy    = (r_state != S_IDLE) || !w_fifo_empty;
    assign fifo_count = r_count;
    assign uart_tx    = r_tx;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: every non-idle state lasts whole bit periods
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_state_next = S_START;
            S_START: if (w_baud_end) w_state_next = S_DATA;
            S_DATA:  if (w_baud_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_baud_end) w_state_next = w_fifo_empty ? S_IDLE : S_START;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: pop strobe and the line level for the coming cycle,
    // so the registered line changes on the same edge as the state
    always_comb begin
        w_pop     = 1'b0;
        w_tx_next = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_pop     = !w_fifo_empty;
                w_tx_next = w_fifo_empty;
            end
            S_START: begin
                w_tx_next = w_baud_end ? r_shift[0] : 1'b0;
            end
            S_DATA: begin
                if (!w_baud_end)              w_tx_next = r_shift[r_bit_idx];
                else if (r_bit_idx == 3'd7)   w_tx_next = 1'b1;
                else                          w_tx_next = r_shift[w_bit_idx_inc];
            end
            S_STOP: begin
                w_pop     = w_baud_end && !w_fifo_empty;
                w_tx_next = !(w_baud_end && !w_fifo_empty);
            end
            default: begin
                w_pop     = 1'b0;
                w_tx_next = 1'b1;
            end
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer datapath: shift register load, bit index, baud timer, line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= 8'd0;
            r_bit_idx <= 3'd0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_baud_end) begin
                r_bit_idx <= w_bit_idx_inc;
            end
            // Every state exit happens at a bit boundary, so wrapping here
            // also restarts the timer on each state entry
            if ((r_state == S_IDLE) || w_baud_end) r_baud <= '0;
            else                                  r_baud <= r_baud + BW'(1);
        end
    end

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: a line monitor decodes frames and compares them
// against a queue of bytes the stimulus expects to appear, in order.
module tb_uart_sender;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_ready;
    logic       tx_busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       uart_tx;

    uart_sender #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .uart_tx    (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb [$];

    int         rx_count = 0;
    int         last_gap = 0;
    int         m_state  = 0;
    int         m_cnt    = 0;
    int         m_gap    = 0;
    logic [7:0] m_byte   = 8'd0;
    logic [7:0] m_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Line monitor: samples on the falling edge, mid-bit for data
    always @(negedge clk) begin
        if (reset) begin
            m_state = 0;
            m_cnt   = 0;
            m_gap   = 0;
        end else if (m_state == 0) begin
            if (uart_tx == 1'b0) begin
                m_state  = 1;
                m_cnt    = 0;
                last_gap = m_gap;
                m_gap    = 0;
            end else begin
                m_gap++;
            end
        end else begin
            m_cnt++;
            if (m_cnt == CPB/2)
                check_eq("start_low", uart_tx, 1'b0);
            if ((m_cnt > CPB) && (m_cnt < 9*CPB) && ((m_cnt % CPB) == CPB/2))
                m_byte = {uart_tx, m_byte[7:1]};
            if (m_cnt == 9*CPB + CPB/2) begin
                check_eq("stop_high", uart_tx, 1'b1);
                check_eq("frame_expected", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    m_exp = sb.pop_front();
                    check_eq("frame_byte", m_byte, m_exp);
                    $display("rx frame %0d: byte=%02h gap=%0d", rx_count, m_byte, last_gap);
                end
                rx_count++;
            end
            if (m_cnt == 10*CPB - 1) m_state = 0;
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_idle_timeout"}, tx_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        logic [9:0] fr;
        int rx0;
        int sent;
        int cyc;

        reset   = 1'b1;
        tx_en   = 1'b0;
        tx_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", uart_tx, 1'b1);
        check_eq("rst_ready", tx_ready, 1'b1);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_count", fifo_count, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single byte: exact cycle-by-cycle line waveform
        rx0 = rx_count;
        tx_data = 8'h55; tx_en = 1'b1; sb.push_back(8'h55);
        @(posedge clk); #1;
        tx_en = 1'b0;
        check_eq("t1_count_after_write", fifo_count, 1);
        check_eq("t1_line_before_start", uart_tx, 1'b1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10*CPB; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("t1_line_cyc%0d", i), uart_tx, fr[i/CPB]);
            check_eq($sformatf("t1_busy_cyc%0d", i), tx_busy, 1'b1);
        end
        @(posedge clk); #1;
        check_eq("t1_busy_end", tx_busy, 1'b0);
        check_eq("t1_line_end", uart_tx, 1'b1);
        check_eq("t1_frames", rx_count - rx0, 1);
        repeat (5) @(posedge clk);
        #1;

        // Back-to-back: two writes on consecutive cycles
        rx0 = rx_count;
        tx_data = 8'hA5; tx_en = 1'b1; sb.push_back(8'hA5);
        @(posedge clk); #1;
        check_eq("t2_busy_w0", tx_busy, 1'b1);
        tx_data = 8'h3C; sb.push_back(8'h3C);
        @(posedge clk); #1;
        tx_en = 1'b0;
        check_eq("t2_busy_w1", tx_busy, 1'b1);
        for (int i = 0; i < 20*CPB - 1; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("t2_busy_cyc%0d", i), tx_busy, 1'b1);
        end
        @(posedge clk); #1;
        check_eq("t2_busy_end", tx_busy, 1'b0);
        check_eq("t2_frames", rx_count - rx0, 2);
        check_eq("t2_no_gap", last_gap, 0);
        repeat (5) @(posedge clk);
        #1;

        // Full FIFO: six writes on consecutive cycles, last one dropped
        rx0 = rx_count;
        for (int i = 1; i <= 6; i++) begin
            tx_data = 8'(i); tx_en = 1'b1;
            if (i <= 5) sb.push_back(8'(i));
            @(posedge clk); #1;
        end
        tx_en = 1'b0;
        check_eq("t3_count_full", fifo_count, DEPTH);
        check_eq("t3_ready_full", tx_ready, 1'b0);
        wait_idle("t3");
        check_eq("t3_frames", rx_count - rx0, 5);

        // Wrap-around: ten bytes paced by tx_ready
        rx0  = rx_count;
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 3000) begin
            if (tx_ready) begin
                tx_data = 8'(8'h10 + sent); tx_en = 1'b1;
                sb.push_back(8'(8'h10 + sent));
                sent++;
            end else begin
                tx_en = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            check_eq("t4_count_le_depth", (fifo_count <= DEPTH), 1'b1);
        end
        tx_en = 1'b0;
        check_eq("t4_sent", sent, 10);
        wait_idle("t4");
        check_eq("t4_frames", rx_count - rx0, 10);

        // Reset during data bit 3 of 0xFF with two bytes queued
        tx_data = 8'hFF; tx_en = 1'b1; sb.push_back(8'hFF);
        @(posedge clk); #1;
        tx_data = 8'h11; sb.push_back(8'h11);
        @(posedge clk); #1;
        tx_data = 8'h22; sb.push_back(8'h22);
        @(posedge clk); #1;
        tx_en = 1'b0;
        check_eq("t5_queued", fifo_count, 2);
        repeat (16) @(posedge clk);
        #2;
        check_eq("t5_busy_before", tx_busy, 1'b1);
        rx0 = rx_count;
        reset = 1'b1;
        sb.delete();
        #1;
        check_eq("t5_rst_tx", uart_tx, 1'b1);
        check_eq("t5_rst_count", fifo_count, 0);
        check_eq("t5_rst_ready", tx_ready, 1'b1);
        check_eq("t5_rst_busy", tx_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 15*CPB; i++) begin
            @(posedge clk); #1;
            check_eq("t5_quiet_line", uart_tx, 1'b1);
        end
        check_eq("t5_no_frames", rx_count - rx0, 0);
        check_eq("t5_quiet_busy", tx_busy, 1'b0);

        rx0 = rx_count;
        tx_data = 8'h81; tx_en = 1'b1; sb.push_back(8'h81);
        @(posedge clk); #1;
        tx_en = 1'b0;
        wait_idle("t5_after");
        check_eq("t5_after_frames", rx_count - rx0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_sender.md
# uart_sender

UART transmitter peripheral for the MIPS CPU; drives the `uart_tx` pin as the counterpart of the CPU's `uart_rx` receive path. It accepts bytes from the CPU's peripheral write port into a small FIFO and serialises them as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a parameterised bit period. It exposes ready/busy status for the CPU's UART control register.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range ≥2.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to enqueue.
- `tx_en`  in  1  write strobe; enqueues `tx_data` on an edge where `tx_ready`=1.
- `tx_ready`  out  1  FIFO not full (`count < DEPTH`); combinational from `count`.
- `tx_busy`  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- `fifo_count`  out  $clog2(DEPTH)+1  number of queued bytes, excluding the one being shifted.
- `uart_tx`  out  1  serial line; idle high; registered output.

## Operation
- FIFO: circular buffer with wrapping read/write pointers and a `count` register.
  - Push occurs when `tx_en && tx_ready`.
  - Pop occurs when the FSM loads a byte.
  - Push and pop in the same cycle are legal when `count < DEPTH`; `count` is unchanged.
  - `tx_en` while full is ignored; no data is overwritten and no error is flagged.
- FSM states:
  - IDLE: `uart_tx`=1. If `count != 0`, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx` = shift[index] for `CLKS_PER_BIT` cycles per bit, index 0..7. After bit 7 completes, go to STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles. On completion:
    - If `count != 0`, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at the end of each bit. It is reset to 0 on every state entry.
- Bytes are transmitted in write order. The byte in the shift register is unaffected by later writes.
- `tx_busy` = (state != IDLE) || (`count` != 0).

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - `uart_tx`=1, state=IDLE, `count`=0, pointers=0.
  - `tx_ready`=1, `tx_busy`=0, `fifo_count`=0.
  - The partial frame is abandoned; FIFO contents are discarded.
- Latency, for a write at edge N into an empty FIFO while IDLE:
  - `count`=1 after edge N.
  - At edge N+1 the FSM pops, and `uart_tx` goes 0 from edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles:
  - Start bit from edge N+1 to edge N+1+`CLKS_PER_BIT`.
  - Data bit k begins at edge N+1+(k+1)×`CLKS_PER_BIT`.
  - Stop bit ends at edge N+1+10×`CLKS_PER_BIT`.
- Back-to-back frames: the next start bit begins on the same edge that ends the previous stop bit. Line-low time never overlaps a stop bit.
- `tx_ready` deasserts in the cycle after the push that makes `count`=`DEPTH`. It reasserts in the cycle after the pop that frees an entry.
- Pointer wrap: after `DEPTH` pushes the write pointer returns to 0; ordering across wrap must be preserved.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: write 0x55 while idle.
  - Required: `uart_tx` is low for 4 cycles starting 1 cycle after the write.
  - Then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles.
  - Then IDLE with `tx_busy`=0 after 40 cycles.
- Back-to-back: write 0xA5, then 0x3C on the next cycle.
  - Required: two contiguous frames with no idle cycle between them.
  - Data bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
  - `tx_busy` stays 1 for 80 cycles.
- Full FIFO, `DEPTH`=4: write 0x01..0x06 on 6 consecutive cycles starting while idle.
  - Required: 0x01 is popped after 1 cycle; 0x02–0x05 are queued; `fifo_count`=4 and `tx_ready`=0; 0x06 is dropped.
  - The line shows frames 0x01..0x05 in order.
- Wrap-around: send 10 bytes 0x10..0x19, writing only when `tx_ready`=1.
  - Required: all 10 frames appear in order; `fifo_count` never exceeds 4.
- Reset mid-frame: assert `reset` during data bit 3 of 0xFF, with 2 bytes queued.
  - Required: `uart_tx`=1 immediately, `fifo_count`=0, `tx_ready`=1, `tx_busy`=0.
  - No further frames after release. A new write of 0x81 then transmits correctly.
